// File: rtl/blake2s_pkg.sv
// Shared constants, FSM state type and byte-lane helpers for the BLAKE2s message packer.
package blake2s_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  // Byte counts above 4 saturate to a full word.
  function automatic logic [2:0] lane_bytes(input logic [2:0] nbytes);
    return (nbytes > 3'd4) ? 3'd4 : nbytes;
  endfunction

  // Keeps the first nbytes bytes of a word, counted from bits [31:24] downward.
  function automatic logic [31:0] lane_mask(input logic [2:0] nbytes);
    logic [31:0] mask;
    case (lane_bytes(nbytes))
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'hFF00_0000;
      3'd2:    mask = 32'hFFFF_0000;
      3'd3:    mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/blake2s_msg_packer.sv
// Packs a 32-bit byte stream into zero-padded 512-bit BLAKE2s message blocks and
// tracks the running byte counter t.
module blake2s_msg_packer
  import blake2s_pkg::*;
#(
  parameter int T_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        s_data,
  input  logic               s_valid,
  input  logic               s_last,
  input  logic [2:0]         s_bytes,
  output logic               s_ready,
  output logic [511:0]       m,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_final,
  output logic [T_WIDTH-1:0] m_t
);

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [T_WIDTH-1:0]   cnt_q, cnt_d;
  logic                 final_q, final_d;
  logic [31:0]          words_q [BLOCK_WORDS];
  logic [31:0]          words_d [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      final_q <= 1'b0;
      for (int k = 0; k < BLOCK_WORDS; k++) words_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      final_q <= final_d;
      for (int k = 0; k < BLOCK_WORDS; k++) words_q[k] <= words_d[k];
    end
  end

  // Unwritten words stay zero because the buffer is cleared on every load,
  // so padding after the last word comes for free.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    final_d = final_q;
    for (int k = 0; k < BLOCK_WORDS; k++) words_d[k] = words_q[k];

    case (state_q)
      FILL: begin
        if (s_valid) begin
          words_d[idx_q] = s_last ? (s_data & lane_mask(s_bytes)) : s_data;
          idx_d          = idx_q + 4'd1;
          cnt_d          = cnt_q + (s_last ? T_WIDTH'(lane_bytes(s_bytes)) : T_WIDTH'(4));
          if (s_last) begin
            final_d = 1'b1;
            state_d = OUT;
          end else if (idx_q == 4'd15) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          for (int k = 0; k < BLOCK_WORDS; k++) words_d[k] = '0;
          idx_d   = '0;
          final_d = 1'b0;
          if (final_q) cnt_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    m = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) m[511-32*k -: 32] = words_q[k];
  end

  assign s_ready = (state_q == FILL);
  assign m_valid = (state_q == OUT);
  assign m_final = final_q;
  assign m_t     = cnt_q;

  a_m_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (m_valid && !m_ready) |=> $stable(m));

  a_no_overlap : assert property (@(posedge clk) disable iff (!reset_n)
    !(s_ready && m_valid));

endmodule

// File: tb/tb_blake2s_msg_packer.sv
// Directed, table-driven bench for blake2s_msg_packer with hand-computed expected blocks.
module tb_blake2s_msg_packer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [2:0]   s_bytes = '0;
  logic         s_ready;
  logic [511:0] m;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_final;
  logic [63:0]  m_t;

  int testsRun = 0;
  int testsFailed = 0;

  blake2s_msg_packer #(.T_WIDTH(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_bytes (s_bytes),
    .s_ready (s_ready),
    .m       (m),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_final (m_final),
    .m_t     (m_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic [31:0] expWord;
    logic [63:0] expT;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one word and holds it until the packer takes it.
  task automatic applyStimulus(input logic [31:0] data, input logic last, input logic [2:0] nbytes);
    int guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", 512'(s_ready), 512'(1));
    s_data  = data;
    s_last  = last;
    s_bytes = nbytes;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitBlock(output int lat);
    lat = 0;
    @(negedge clk);
    while (!m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!m_valid) checkOutput("m_valid_timeout", 512'(m_valid), 512'(1));
  endtask

  task automatic loadBlock();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  function automatic logic [31:0] wordOf(input logic [511:0] blk, input int k);
    return blk[511-32*k -: 32];
  endfunction

  task automatic checkBlock(input string name, input logic [511:0] expM,
                            input logic expFinal, input logic [63:0] expT);
    checkOutput({name, "_m"}, m, expM);
    checkOutput({name, "_final"}, 512'(m_final), 512'(expFinal));
    checkOutput({name, "_t"}, 512'(m_t), 512'(expT));
  endtask

  initial begin
    int lat;
    logic [511:0] expM;
    logic [511:0] held;

    vecs[0] = '{"empty",      32'hDEADBEEF, 3'd0, 32'h0000_0000, 64'd0};
    vecs[1] = '{"abc",        32'h61626300, 3'd3, 32'h6162_6300, 64'd3};
    vecs[2] = '{"one_byte",   32'hDEADBEEF, 3'd1, 32'hDE00_0000, 64'd1};
    vecs[3] = '{"two_bytes",  32'hDEADBEEF, 3'd2, 32'hDEAD_0000, 64'd2};
    vecs[4] = '{"three_mask", 32'h61626399, 3'd3, 32'h6162_6300, 64'd3};
    vecs[5] = '{"four_bytes", 32'h01234567, 3'd4, 32'h0123_4567, 64'd4};
    vecs[6] = '{"bytes_7",    32'hCAFEF00D, 3'd7, 32'hCAFE_F00D, 64'd4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_m", m, 512'(0));
    checkOutput("reset_valid", 512'(m_valid), 512'(0));
    checkOutput("reset_ready", 512'(s_ready), 512'(1));
    checkOutput("reset_final", 512'(m_final), 512'(0));
    checkOutput("reset_t", 512'(m_t), 512'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, 1'b1, vecs[i].nbytes);
      waitBlock(lat);
      if (i == 0) checkOutput("latency", 512'(lat), 512'(0));
      checkOutput({vecs[i].name, "_ready"}, 512'(s_ready), 512'(0));
      checkBlock(vecs[i].name, {vecs[i].expWord, 480'h0}, 1'b1, vecs[i].expT);
      loadBlock();
    end

    // Partial three-word message: 4 + 4 + 3 bytes.
    applyStimulus(32'h01020304, 1'b0, 3'd0);
    applyStimulus(32'h05060708, 1'b0, 3'd0);
    applyStimulus(32'h090A0B0C, 1'b1, 3'd3);
    waitBlock(lat);
    checkBlock("three_word", {32'h01020304, 32'h05060708, 32'h090A0B00, 416'h0}, 1'b1, 64'd11);
    loadBlock();

    // 128-byte message, word k carries value k.
    for (int k = 0; k < 16; k++) applyStimulus(32'(k), 1'b0, 3'd0);
    waitBlock(lat);
    checkOutput("m128_b0_latency", 512'(lat), 512'(0));
    expM = '0;
    for (int k = 0; k < 16; k++) expM[511-32*k -: 32] = 32'(k);
    checkOutput("m128_b0_w0", 512'(wordOf(m, 0)), 512'(0));
    checkOutput("m128_b0_w15", 512'(m[31:0]), 512'(15));
    checkBlock("m128_b0", expM, 1'b0, 64'd64);
    loadBlock();
    for (int k = 16; k < 32; k++) applyStimulus(32'(k), k == 31, 3'd4);
    waitBlock(lat);
    for (int k = 0; k < 16; k++) expM[511-32*k -: 32] = 32'(k + 16);
    checkBlock("m128_b1", expM, 1'b1, 64'd128);
    loadBlock();

    // Output stall: m_ready low for 5 cycles while a new word waits.
    applyStimulus(32'h61626300, 1'b1, 3'd3);
    waitBlock(lat);
    held = m;
    s_data = 32'h11223344; s_last = 1'b1; s_bytes = 3'd4; s_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_m", m, held);
      checkOutput("stall_valid", 512'(m_valid), 512'(1));
      checkOutput("stall_ready", 512'(s_ready), 512'(0));
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    checkOutput("after_load_valid", 512'(m_valid), 512'(0));
    checkOutput("after_load_m", m, 512'(0));
    checkOutput("after_load_t", 512'(m_t), 512'(0));
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    waitBlock(lat);
    checkBlock("held_word", {32'h11223344, 480'h0}, 1'b1, 64'd4);
    loadBlock();

    // Reset after 7 words of a message.
    for (int k = 0; k < 7; k++) applyStimulus(32'hDEAD0000 + 32'(k), 1'b0, 3'd0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_m", m, 512'(0));
    checkOutput("midreset_t", 512'(m_t), 512'(0));
    reset_n = 1'b1;
    applyStimulus(32'h61626300, 1'b1, 3'd3);
    waitBlock(lat);
    checkBlock("post_reset", {32'h61626300, 480'h0}, 1'b1, 64'd3);

    // Reset while a block is pending: it is discarded.
    @(negedge clk);
    reset_n = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    reset_n = 1'b1;
    checkOutput("outreset_valid", 512'(m_valid), 512'(0));
    checkOutput("outreset_final", 512'(m_final), 512'(0));

    // 65-byte message: full block then a single-byte block.
    for (int k = 0; k < 16; k++) applyStimulus(32'hA5000000 + 32'(k), 1'b0, 3'd0);
    waitBlock(lat);
    for (int k = 0; k < 16; k++) expM[511-32*k -: 32] = 32'hA5000000 + 32'(k);
    checkBlock("m65_b0", expM, 1'b0, 64'd64);
    loadBlock();
    applyStimulus(32'hFF000000, 1'b1, 3'd1);
    waitBlock(lat);
    checkBlock("m65_b1", {32'hFF000000, 480'h0}, 1'b1, 64'd65);
    loadBlock();

    // Exactly 64 bytes: no extra padding block afterwards.
    for (int k = 0; k < 16; k++) applyStimulus(32'h5A5A0000 + 32'(k), k == 15, 3'd4);
    waitBlock(lat);
    for (int k = 0; k < 16; k++) expM[511-32*k -: 32] = 32'h5A5A0000 + 32'(k);
    checkBlock("m64", expM, 1'b1, 64'd64);
    loadBlock();
    repeat (3) @(negedge clk);
    checkOutput("m64_no_extra", 512'(m_valid), 512'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
